alu_nbit_seq: RTL and testbench
===============================

Name: alu_nbit_seq

Overview:
- Parametrised N-bit successor of the 1-bit MSB ALU slice.
- Registered datapath that adds a valid/ready handshake, a Zero flag, a correct signed SLT (sign XOR overflow) and multi-cycle iterative shifts.
- Sits between the register-file read stage and writeback. Accepts one operation at a time and holds its result until the consumer takes it.

Parameters:
- WIDTH, 32: operand/result width in bits; legal values are 2 or more.
- SHW, $clog2(WIDTH): shift-amount width; the shift amount is taken from B[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B, or shift amount in bits [SHW-1:0]
- Operation  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 SLL, 100 SRL, 101 SRA
- out_valid  output  1  Result and flags are valid
- out_ready  input  1  consumer takes the result
- Result  output  WIDTH  operation result
- CarryOut  output  1  carry out of the MSB (ADD/SUB/SLT only, else 0)
- Overflow  output  1  signed overflow (ADD/SUB only, else 0)
- Zero  output  1  Result == 0
- busy  output  1  a shift is in progress

Behaviour:
- One clock. Reset is synchronous and active-high.
  - On reset: state=IDLE; in_ready=1 on the following cycle; out_valid=0, busy=0.
  - Result, CarryOut, Overflow and Zero all reset to 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch A, B and Operation.
    - Non-shift op, or shift with shamt=0: go to DONE.
    - Shift with shamt>0: go to SHIFT, with count=shamt.
  - SHIFT: busy=1, in_ready=0. Each cycle, shift the working register 1 bit and decrement count. When count reaches 1, the final shift is applied and the state goes to DONE.
  - DONE: out_valid=1, in_ready=0. Outputs are held stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid.
- Latency, with acceptance at edge T:
  - Non-shift ops: out_valid is high after edge T+1.
  - Shifts of k>0: out_valid is high after edge T+1+k.
  - Maximum throughput is one op per 2 cycles.
- Arithmetic: SUB and SLT compute A + ~B + 1 in WIDTH+1 bits.
  - CarryOut is bit WIDTH of that sum. For SUB, CarryOut=1 means no borrow.
  - Overflow = carry into MSB XOR carry out of MSB. It is reported for ADD and SUB only.
  - SLT: Result = {WIDTH-1 zeros, sum[WIDTH-1] ^ ovf}. CarryOut is reported for SLT; Overflow=0.
- Logical ops: AND, OR and shifts give CarryOut=0 and Overflow=0.
- Shifts:
  - SLL shifts zeros into bit 0.
  - SRL shifts zeros into the MSB.
  - SRA replicates the MSB.
- Zero is computed from the final Result in all cases.
- Inputs while in_ready=0 are ignored. in_valid is sampled only in IDLE.
- Reset mid-SHIFT or mid-DONE aborts the operation. There is no residual out_valid pulse.

Optional Feature:
ALU_SHIFT_EN
- Defined: opcodes 011/100/101 run as iterative shifts, as specified above.
- Undefined:
  - The SHIFT state and counter are not built; busy is tied to 0.
  - Opcodes 011/100/101 complete as single-cycle ops with Result=0, CarryOut=0, Overflow=0 and Zero=1.

Test Plan:
- ADD A=0x7FFFFFFF, B=0x00000001 -> one cycle after accept: Result=0x80000000, Overflow=1, CarryOut=0, Zero=0.
- SUB A=5, B=5 -> Result=0, Zero=1, CarryOut=1, Overflow=0.
- SLT A=0xFFFFFFFF, B=1 -> Result=1. SLT A=0x7FFFFFFF, B=0x80000000 -> Result=0 (this is the overflow case).
- SRA A=0x80000000, B=4 (ALU_SHIFT_EN) -> busy high for 4 cycles, out_valid after edge T+5, Result=0xF8000000. SLL by B=0 -> out_valid at T+1, Result=A.
- Backpressure: ADD completes with out_ready=0 for 3 cycles -> Result, flags and out_valid stable, in_ready=0, and a new in_valid is ignored. out_ready=1 -> IDLE next cycle.
- reset asserted on the 2nd cycle of SLL by 10 -> next cycle out_valid=0, busy=0, Result=0; after reset, in_ready=1 and a fresh ADD completes correctly.

Source files
------------

// File: rtl/alu_nbit_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_nbit_seq
// Brief    : Registered N-bit ALU with valid/ready handshake, Zero flag,
//            signed SLT and optional iterative shifts (macro ALU_SHIFT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alu_nbit_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             busy
);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_SLT = 3'b111;
    localparam logic [2:0] c_OP_SLL = 3'b011;
    localparam logic [2:0] c_OP_SRL = 3'b100;
    localparam logic [2:0] c_OP_SRA = 3'b101;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
`ifdef ALU_SHIFT_EN
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;

    // Shared adder: SUB and SLT use A + ~B + 1, ADD uses A + B.
    logic             w_sub;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_ovf;

    assign w_sub = (Operation != c_OP_ADD);
    assign w_bx  = w_sub ? ~B : B;
    assign w_sum = {1'b0, A} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf = (A[WIDTH-1] ^ w_bx[WIDTH-1] ^ w_sum[WIDTH-1]) ^ w_sum[WIDTH];

`ifdef ALU_SHIFT_EN
    logic [SHW-1:0]   r_count;
    logic [2:0]       r_op;
    logic [SHW-1:0]   w_shamt;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_shifted;

    assign w_shamt    = B[SHW-1:0];
    assign w_is_shift = (Operation == c_OP_SLL) || (Operation == c_OP_SRL) ||
                        (Operation == c_OP_SRA);

    always_comb begin
        w_shifted = r_result;
        case (r_op)
            c_OP_SLL: w_shifted = {r_result[WIDTH-2:0], 1'b0};
            c_OP_SRL: w_shifted = {1'b0, r_result[WIDTH-1:1]};
            c_OP_SRA: w_shifted = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
            default:  w_shifted = r_result;
        endcase
    end
`endif

    always_comb begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        w_alu_ovf    = 1'b0;
        case (Operation)
            c_OP_AND: w_alu_result = A & B;
            c_OP_OR:  w_alu_result = A | B;
            c_OP_ADD, c_OP_SUB: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
                w_alu_ovf    = w_ovf;
            end
            c_OP_SLT: begin
                w_alu_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
                w_alu_carry  = w_sum[WIDTH];
            end
            default: begin
                // A zero-distance shift passes A straight through.
`ifdef ALU_SHIFT_EN
                w_alu_result = A;
`else
                w_alu_result = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SHIFT_EN
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_next_state = c_ST_SHIFT;
                    end else begin
                        w_next_state = c_ST_DONE;
                    end
`else
                    w_next_state = c_ST_DONE;
`endif
                end
            end
`ifdef ALU_SHIFT_EN
            c_ST_SHIFT: begin
                if (r_count == SHW'(1)) begin
                    w_next_state = c_ST_DONE;
                end
            end
`endif
            c_ST_DONE: begin
                if (out_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_ST_IDLE);
        out_valid = (r_state == c_ST_DONE);
`ifdef ALU_SHIFT_EN
        busy      = (r_state == c_ST_SHIFT);
`else
        busy      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
`ifdef ALU_SHIFT_EN
            r_count  <= '0;
            r_op     <= 3'b000;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
`ifdef ALU_SHIFT_EN
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_result <= A;
                            r_carry  <= 1'b0;
                            r_ovf    <= 1'b0;
                            r_zero   <= (A == '0);
                            r_count  <= w_shamt;
                            r_op     <= Operation;
                        end else
`endif
                        begin
                            r_result <= w_alu_result;
                            r_carry  <= w_alu_carry;
                            r_ovf    <= w_alu_ovf;
                            r_zero   <= (w_alu_result == '0);
                        end
                    end
                end
`ifdef ALU_SHIFT_EN
                c_ST_SHIFT: begin
                    r_result <= w_shifted;
                    r_zero   <= (w_shifted == '0);
                    r_count  <= r_count - SHW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign Result   = r_result;
    assign CarryOut = r_carry;
    assign Overflow = r_ovf;
    assign Zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_nbit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_nbit_seq
// Brief    : Self-checking bench for alu_nbit_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_nbit_seq;

    localparam int c_W = 32;
`ifdef ALU_SHIFT_EN
    localparam bit c_SHIFT_EN = 1'b1;
`else
    localparam bit c_SHIFT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] A;
    logic [c_W-1:0] B;
    logic [2:0]     Operation;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] Result;
    logic           CarryOut;
    logic           Overflow;
    logic           Zero;
    logic           busy;

    int n_vec = 0;
    int n_mis = 0;

    alu_nbit_seq #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Operation (Operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .CarryOut  (CarryOut),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_shift(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    endfunction

    // Returns {carry, overflow, result} from the architectural rules.
    function automatic logic [c_W+1:0] model(input logic [2:0] op, input logic [c_W-1:0] a,
                                             input logic [c_W-1:0] b);
        logic [c_W-1:0] r;
        logic           c;
        logic           v;
        logic [c_W:0]   s;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[c_W-1:0]; c = s[c_W];
                v = (a[c_W-1] == b[c_W-1]) && (r[c_W-1] != a[c_W-1]);
            end
            3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[c_W-1:0]; c = (a >= b);
                v = (a[c_W-1] != b[c_W-1]) && (r[c_W-1] != a[c_W-1]);
            end
            3'b111: begin
                r = ($signed(a) < $signed(b)) ? 1 : 0;
                c = (a >= b);
            end
            3'b011: r = c_SHIFT_EN ? (a << b[4:0]) : '0;
            3'b100: r = c_SHIFT_EN ? (a >> b[4:0]) : '0;
            default: r = c_SHIFT_EN ? c_W'($signed(a) >>> b[4:0]) : '0;
        endcase
        return {c, v, r};
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                         input int hold);
        logic [c_W+1:0] m;
        int lat;
        int guard;
        m   = model(op, a, b);
        lat = (c_SHIFT_EN && is_shift(op)) ? int'(b[4:0]) : 0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; A = a; B = b; Operation = op; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom;
        for (int i = 0; i < lat; i++) begin
            check("busy_shift", busy, 1);
            check("out_valid_shift", out_valid, 0);
            check("in_ready_shift", in_ready, 0);
            @(posedge clk); #1;
        end
        check("out_valid", out_valid, 1);
        check("busy_done", busy, 0);
        check("in_ready_done", in_ready, 0);
        check("result", Result, m[c_W-1:0]);
        check("carry", CarryOut, m[c_W+1]);
        check("overflow", Overflow, m[c_W]);
        check("zero", Zero, (m[c_W-1:0] == '0));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; Operation = 3'($urandom); A = $urandom; B = $urandom;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", Result, m[c_W-1:0]);
            check("hold_flags", {CarryOut, Overflow, Zero},
                  {m[c_W+1], m[c_W], (m[c_W-1:0] == '0)});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", out_valid, 0);
        check("back_idle", in_ready, 1);
    endtask

    initial begin
        logic [c_W-1:0] ra;
        logic [c_W-1:0] rb;
        logic [2:0]     rop;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Operation = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", Result, 0);
        check("rst_flags", {CarryOut, Overflow, Zero}, 3'b000);

        do_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op(3'b110, 32'd5, 32'd5, 0);
        do_op(3'b110, 32'd3, 32'd7, 0);
        do_op(3'b111, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        do_op(3'b110, 32'h8000_0000, 32'd1, 0);
        do_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        do_op(3'b001, 32'h0000_0000, 32'h0000_0000, 0);
        do_op(3'b101, 32'h8000_0000, 32'd4, 0);
        do_op(3'b011, 32'hDEAD_BEEF, 32'd0, 0);
        do_op(3'b100, 32'h8000_0001, 32'd31, 0);
        do_op(3'b010, 32'h1234_5678, 32'h1111_1111, 3);

        // Reset during the second cycle of a long shift must abort it cleanly.
        in_valid = 1'b1; A = 32'h0000_00FF; B = 32'd10; Operation = 3'b011;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", Result, 0);
        check("abort_in_ready", in_ready, 1);
        do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 0);

        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = ra;
                2: rb = 32'h7FFF_FFFF;
                default: ;
            endcase
            do_op(rop, ra, rb, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
